// File: rtl/mod_counter_pkg.sv
// -----------------------------------------------------------------------------
// mod_counter_pkg
// Shared definitions for the seconds/minutes digit-counter chain. The decade
// stage (mod10_carry_counter) and the downstream mod-6 stage both use it.
//   DIGIT_W       : width of one BCD-style digit
//   digit_t       : digit type
//   DEFAULT_MOD10 : default modulus of the units stage
//   clamp_digit() : limits a loaded value to 0..modulus-1
// -----------------------------------------------------------------------------
package mod_counter_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned DEFAULT_MOD10 = 10;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Saturate a loaded value to the largest legal digit so q can never leave
  // 0..modulus-1. The comparison is done in the 4-bit digit domain.
  function automatic digit_t clamp_digit(input digit_t val, input int unsigned modulus);
    digit_t max_digit;
    max_digit = digit_t'(modulus - 32'd1);
    if (val > max_digit) begin
      return max_digit;
    end else begin
      return val;
    end
  endfunction

endpackage : mod_counter_pkg

// File: rtl/mod10_carry_counter_if.sv
// -----------------------------------------------------------------------------
// mod10_carry_counter_if
// Control/status bundle of the decade counter stage.
//   en, load, load_val, up_dn : controls (driven by the master)
//   q, tc, carry              : digit status (driven by the slave, the counter)
// up_dn is only present when MOD10_CARRY_DOWN_EN is defined.
// -----------------------------------------------------------------------------
interface mod10_carry_counter_if;
  import mod_counter_pkg::*;

  logic   en;
  logic   load;
  digit_t load_val;
`ifdef MOD10_CARRY_DOWN_EN
  logic   up_dn;
`endif
  digit_t q;
  logic   tc;
  logic   carry;

  modport master (
    output en, load, load_val,
`ifdef MOD10_CARRY_DOWN_EN
    output up_dn,
`endif
    input  q, tc, carry
  );

  modport slave (
    input  en, load, load_val,
`ifdef MOD10_CARRY_DOWN_EN
    input  up_dn,
`endif
    output q, tc, carry
  );

endinterface : mod10_carry_counter_if

// File: rtl/mod10_carry_counter_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk into single-cycle count ticks: one tick every PRESCALE enabled
// cycles. The count freezes while en is low and resumes where it stopped.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   en    : advance enable
//   clr   : synchronous clear (driven by the digit load)
//   tick  : combinational, en && count at its last value
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // PRESCALE = 1 still needs a 1-bit counter; it simply stays at zero.
  localparam int unsigned    CNT_W = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 32'd1);

  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] pcnt_d;

  // Tick decode and next prescale count; clear wins over advancing.
  always_comb begin
    tick   = en && (pcnt_q == LAST);
    pcnt_d = pcnt_q;
    if (clr) begin
      pcnt_d = {CNT_W{1'b0}};
    end else if (tick) begin
      pcnt_d = {CNT_W{1'b0}};
    end else if (en) begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Prescale count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= {CNT_W{1'b0}};
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule : tick_prescaler

// File: rtl/mod10_carry_counter.sv
// -----------------------------------------------------------------------------
// mod10_carry_counter
// Prescaled mod-MODULUS digit counter (units digit of a seconds/minutes
// chain). carry is a registered one-cycle pulse on wrap and serves as the
// count enable of the next (tens) stage.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears digit, carry and prescaler
//   bus   : slave side of mod10_carry_counter_if
//           en/load/load_val[/up_dn] in, q/tc/carry out
// Optional feature macro: MOD10_CARRY_DOWN_EN adds up_dn and down counting
// with borrow on wrap; without it the block counts up only.
// Priority each cycle: reset > load > tick > hold.
// -----------------------------------------------------------------------------
module mod10_carry_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned MODULUS  = DEFAULT_MOD10
) (
  input  logic clk,
  input  logic reset,
  mod10_carry_counter_if.slave bus
);

  localparam digit_t MAX_DIGIT = digit_t'(MODULUS - 32'd1);

  logic   tick_s;
  digit_t q_q;
  digit_t q_d;
  logic   carry_q;
  logic   carry_d;

  // Load clears the prescaler so the loaded digit gets a full prescale period.
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (tick_s)
  );

  // Next digit and carry; carry only pulses on a wrapping tick, never on load.
  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    if (bus.load) begin
      q_d = clamp_digit(bus.load_val, MODULUS);
    end else if (tick_s) begin
`ifdef MOD10_CARRY_DOWN_EN
      if (bus.up_dn) begin
        if (q_q == MAX_DIGIT) begin
          q_d     = 4'd0;
          carry_d = 1'b1;
        end else begin
          q_d     = q_q + 4'd1;
        end
      end else begin
        if (q_q == 4'd0) begin
          q_d     = MAX_DIGIT;
          carry_d = 1'b1;
        end else begin
          q_d     = q_q - 4'd1;
        end
      end
`else
      if (q_q == MAX_DIGIT) begin
        q_d     = 4'd0;
        carry_d = 1'b1;
      end else begin
        q_d     = q_q + 4'd1;
      end
`endif
    end else begin
      q_d = q_q;
    end
  end

  // Digit and carry registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= 4'd0;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
    end
  end

  // Terminal count follows the registered digit with no extra latency.
  always_comb begin
`ifdef MOD10_CARRY_DOWN_EN
    if (bus.up_dn) begin
      bus.tc = (q_q == MAX_DIGIT);
    end else begin
      bus.tc = (q_q == 4'd0);
    end
`else
    bus.tc = (q_q == MAX_DIGIT);
`endif
  end

  assign bus.q     = q_q;
  assign bus.carry = carry_q;

endmodule : mod10_carry_counter

// File: tb/tb_mod10_carry_counter.sv
// Directed bench for mod10_carry_counter with PRESCALE=4, MODULUS=10.
// Define MOD10_CARRY_DOWN_EN to also exercise the down-counting path.
module tb_mod10_carry_counter;

  logic clk;
  logic reset;
  int   passed;
  int   total;

  mod10_carry_counter_if bus ();

  mod10_carry_counter #(
    .PRESCALE (4),
    .MODULUS  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; return 1 time unit after the last one.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    reset        = 1'b1;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
`ifdef MOD10_CARRY_DOWN_EN
    bus.up_dn    = 1'b1;
`endif
    cyc(2);
    chk("reset_q", {4'd0, bus.q}, 8'd0);
    chk("reset_carry", {7'd0, bus.carry}, 8'd0);
    chk("reset_tc", {7'd0, bus.tc}, 8'd0);

    // 1: full decade, q steps every 4 cycles, carry only at cycle 40
    reset  = 1'b0;
    bus.en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      chk("run_q", {4'd0, bus.q}, 8'((i / 4) % 10));
      chk("run_carry", {7'd0, bus.carry}, (i == 40) ? 8'd1 : 8'd0);
      chk("run_tc", {7'd0, bus.tc}, (((i / 4) % 10) == 9) ? 8'd1 : 8'd0);
    end

    // 2: stall at q=5 mid-prescale (pcnt=2), then resume
    cyc(22);
    chk("pre_stall_q", {4'd0, bus.q}, 8'd5);
    bus.en = 1'b0;
    cyc(7);
    chk("stall_q", {4'd0, bus.q}, 8'd5);
    bus.en = 1'b1;
    cyc(1);
    chk("resume1_q", {4'd0, bus.q}, 8'd5);
    cyc(1);
    chk("resume2_q", {4'd0, bus.q}, 8'd6);

    // 3: clamped load of 12 gives 9, next tick wraps with carry
    bus.load     = 1'b1;
    bus.load_val = 4'd12;
    cyc(1);
    bus.load     = 1'b0;
    chk("clamp_q", {4'd0, bus.q}, 8'd9);
    chk("clamp_carry", {7'd0, bus.carry}, 8'd0);
    chk("clamp_tc", {7'd0, bus.tc}, 8'd1);
    cyc(3);
    chk("clamp_hold_q", {4'd0, bus.q}, 8'd9);
    cyc(1);
    chk("clamp_wrap_q", {4'd0, bus.q}, 8'd0);
    chk("clamp_wrap_carry", {7'd0, bus.carry}, 8'd1);
    cyc(1);
    chk("carry_one_cycle", {7'd0, bus.carry}, 8'd0);

    // 4: load coincides with wrapping tick at q=9
    bus.load     = 1'b1;
    bus.load_val = 4'd9;
    cyc(1);
    bus.load     = 1'b0;
    cyc(3);
    bus.load     = 1'b1;
    bus.load_val = 4'd3;
    cyc(1);
    bus.load     = 1'b0;
    chk("load_vs_tick_q", {4'd0, bus.q}, 8'd3);
    chk("load_vs_tick_carry", {7'd0, bus.carry}, 8'd0);
    cyc(3);
    chk("load_pcnt_clr_q", {4'd0, bus.q}, 8'd3);
    cyc(1);
    chk("load_next_tick_q", {4'd0, bus.q}, 8'd4);

    // 5: reset with a wrap pending; next carry after a full 40 cycles
    bus.load     = 1'b1;
    bus.load_val = 4'd9;
    cyc(1);
    bus.load     = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mid_reset_q", {4'd0, bus.q}, 8'd0);
    chk("mid_reset_carry", {7'd0, bus.carry}, 8'd0);
    for (int i = 1; i <= 39; i++) begin
      cyc(1);
      chk("post_reset_carry", {7'd0, bus.carry}, 8'd0);
    end
    chk("post_reset_q39", {4'd0, bus.q}, 8'd9);
    cyc(1);
    chk("post_reset_q40", {4'd0, bus.q}, 8'd0);
    chk("post_reset_carry40", {7'd0, bus.carry}, 8'd1);

`ifdef MOD10_CARRY_DOWN_EN
    // 6: down counting from 0 borrows to 9, tc high only at q==0
    reset     = 1'b1;
    bus.up_dn = 1'b0;
    cyc(1);
    reset     = 1'b0;
    chk("down_reset_tc", {7'd0, bus.tc}, 8'd1);
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      chk("down_q", {4'd0, bus.q}, 8'((10 - ((i / 4) % 10)) % 10));
      chk("down_carry", {7'd0, bus.carry}, ((i % 4 == 0) && ((i / 4) % 10 == 1)) ? 8'd1 : 8'd0);
      chk("down_tc", {7'd0, bus.tc}, ((i / 4) % 10 == 0) ? 8'd1 : 8'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mod10_carry_counter
